// File: rtl/rd_burst_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_burst_master_pkg
// Description : Shared FSM states, AXI constants and sizing helper for the
//               read burst master.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_burst_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_burst_incr = 2'b01;
    localparam logic [1:0] c_resp_okay  = 2'b00;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module      : rd_burst_master_if
// Description : Command, AXI4 AR/R and user read-port bundle of the read
//               burst master.
// Revision    : 1.0 - initial release
// ============================================================================
interface rd_burst_master_if #(
    parameter int P_AXI_DATA_WIDTH = 128,
    parameter int P_AXI_ADDR_WIDTH = 32
);
    logic                        i_axi_u2a_rden;
    logic [P_AXI_ADDR_WIDTH-1:0] i_axi_u2a_addr;
    logic [7:0]                  i_axi_u2a_length;
    logic                        o_buffer_ready;

    logic [3:0]                  o_m_axi_arid;
    logic [P_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr;
    logic [7:0]                  o_m_axi_arlen;
    logic [2:0]                  o_m_axi_arsize;
    logic [1:0]                  o_m_axi_arburst;
    logic                        o_m_axi_arvalid;
    logic                        i_m_axi_arready;

    logic [P_AXI_DATA_WIDTH-1:0] i_m_axi_rdata;
    logic [1:0]                  i_m_axi_rresp;
    logic                        i_m_axi_rlast;
    logic                        i_m_axi_rvalid;
    logic                        o_m_axi_rready;

    logic [P_AXI_DATA_WIDTH-1:0] o_user_rd_data;
    logic                        o_user_rd_valid;
    logic                        i_user_rd_ready;
    logic                        o_rd_err;

    modport master (
        input  i_axi_u2a_rden, i_axi_u2a_addr, i_axi_u2a_length,
        output o_buffer_ready,
        output o_m_axi_arid, o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arsize,
        output o_m_axi_arburst, o_m_axi_arvalid,
        input  i_m_axi_arready,
        input  i_m_axi_rdata, i_m_axi_rresp, i_m_axi_rlast, i_m_axi_rvalid,
        output o_m_axi_rready,
        output o_user_rd_data, o_user_rd_valid,
        input  i_user_rd_ready,
        output o_rd_err
    );

    modport slave (
        output i_axi_u2a_rden, i_axi_u2a_addr, i_axi_u2a_length,
        input  o_buffer_ready,
        input  o_m_axi_arid, o_m_axi_araddr, o_m_axi_arlen, o_m_axi_arsize,
        input  o_m_axi_arburst, o_m_axi_arvalid,
        output i_m_axi_arready,
        output i_m_axi_rdata, i_m_axi_rresp, i_m_axi_rlast, i_m_axi_rvalid,
        input  o_m_axi_rready,
        input  o_user_rd_data, o_user_rd_valid,
        output i_user_rd_ready,
        input  o_rd_err
    );
endinterface
`default_nettype wire

// File: rtl/rd_burst_master_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rd_data_fifo
// Description : Synchronous FIFO with a registered output stage; a write into
//               an empty FIFO bypasses the memory straight to the output.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_data_fifo
    import rd_burst_master_pkg::*;
#(
    parameter int P_WIDTH = 128,
    parameter int P_DEPTH = 512
) (
    input  wire logic               i_user_clk,
    input  wire logic               r_user_rst,
    input  wire logic               i_wr_en,
    input  wire logic [P_WIDTH-1:0] i_wr_data,
    input  wire logic               i_rd_en,
    output logic      [P_WIDTH-1:0] o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int c_aw = log2(P_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full = c_cw'(P_DEPTH);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic [P_WIDTH-1:0] r_rd_data;
    logic               r_rd_valid;

    logic w_mem_empty;
    logic w_load;
    logic w_mem_rd;
    logic w_bypass;
    logic w_mem_wr;

    assign w_mem_empty = (r_count == '0);
    // Output slot is free for new data when empty or being popped now.
    assign w_load      = !r_rd_valid || i_rd_en;
    assign w_mem_rd    = w_load && !w_mem_empty;
    assign w_bypass    = w_load && w_mem_empty && i_wr_en;
    assign w_mem_wr    = i_wr_en && !w_bypass && !o_full;

    assign o_full     = (r_count == c_full);
    assign o_empty    = !r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

    always_ff @(posedge i_user_clk) begin
        if (w_mem_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_user_clk or posedge r_user_rst) begin
        if (r_user_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_mem_wr) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_mem_rd) r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_mem_wr, w_mem_rd})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
            if (w_mem_rd) begin
                r_rd_data  <= r_mem[r_rd_ptr];
                r_rd_valid <= 1'b1;
            end else if (w_bypass) begin
                r_rd_data  <= i_wr_data;
                r_rd_valid <= 1'b1;
            end else if (w_load) begin
                r_rd_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rd_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : rd_burst_master
// Description : Issues one AXI4 INCR read burst per accepted command and
//               streams the returned beats through a credit-guarded FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_burst_master
    import rd_burst_master_pkg::*;
#(
    parameter int P_AXI_DATA_WIDTH = 128,
    parameter int P_AXI_ADDR_WIDTH = 32,
    parameter int P_AXI_ID         = 0,
    parameter int P_BUF_DEPTH      = 512,
    parameter int P_BURST_MAX      = 256
) (
    input  wire logic          i_user_clk,
    input  wire logic          r_user_rst,
    rd_burst_master_if.master  bus
);
    localparam int c_cred_w = log2(P_BUF_DEPTH) + 1;
    localparam logic [c_cred_w-1:0] c_depth     = c_cred_w'(P_BUF_DEPTH);
    localparam logic [c_cred_w-1:0] c_burst_max = c_cred_w'(P_BURST_MAX);
    localparam logic [c_cred_w-1:0] c_one       = c_cred_w'(1);

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_buffer_ready;
    logic                        r_arvalid;
    logic                        r_rready;
    logic                        r_rd_err;
    logic [P_AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]                  r_arlen;
    logic [8:0]                  r_beat_cnt;
    logic [c_cred_w-1:0]         r_credits;
    logic [c_cred_w-1:0]         w_credits_take;
    logic [c_cred_w-1:0]         w_credits_next;

    logic                        w_accept;
    logic                        w_beat;
    logic                        w_pop;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic                        w_fifo_valid;
    logic [P_AXI_DATA_WIDTH-1:0] w_fifo_data;
    logic                        w_beat_bad;

    assign w_accept = bus.i_axi_u2a_rden && r_buffer_ready;
    assign w_beat   = r_rready && bus.i_m_axi_rvalid;
    assign w_pop    = !w_fifo_empty && bus.i_user_rd_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)              w_state_next = ST_AR;
            ST_AR:   if (bus.i_m_axi_arready)   w_state_next = ST_R;
            ST_R:    if (w_beat && bus.i_m_axi_rlast) w_state_next = ST_DONE;
            ST_DONE:                            w_state_next = ST_IDLE;
            default:                            w_state_next = ST_IDLE;
        endcase
    end

    // Reserve the whole burst at accept; each pop returns one credit. The
    // clamp only matters after an overlong (erroneous) burst.
    assign w_credits_take = r_credits -
        (w_accept ? (c_cred_w'(bus.i_axi_u2a_length) + c_one) : '0);
    assign w_credits_next = (w_pop && (w_credits_take != c_depth)) ?
                            (w_credits_take + c_one) : w_credits_take;

    always_ff @(posedge i_user_clk or posedge r_user_rst) begin
        if (r_user_rst) begin
            r_state        <= ST_IDLE;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_buffer_ready <= 1'b0;
            r_credits      <= c_depth;
        end else begin
            r_state        <= w_state_next;
            r_arvalid      <= (w_state_next == ST_AR);
            r_rready       <= (w_state_next == ST_R);
            r_buffer_ready <= (w_state_next == ST_IDLE) &&
                              (w_credits_next >= c_burst_max) && !w_accept;
            r_credits      <= w_credits_next;
        end
    end

    assign w_beat_bad = (bus.i_m_axi_rresp != c_resp_okay) ||
                        ( bus.i_m_axi_rlast && (r_beat_cnt != {1'b0, r_arlen})) ||
                        (!bus.i_m_axi_rlast && (r_beat_cnt == {1'b0, r_arlen}));

    always_ff @(posedge i_user_clk or posedge r_user_rst) begin
        if (r_user_rst) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_beat_cnt <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_araddr   <= bus.i_axi_u2a_addr;
                r_arlen    <= bus.i_axi_u2a_length;
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            if (w_beat && w_beat_bad) r_rd_err <= 1'b1;
        end
    end

    rd_data_fifo #(
        .P_WIDTH (P_AXI_DATA_WIDTH),
        .P_DEPTH (P_BUF_DEPTH)
    ) u_rd_data_fifo (
        .i_user_clk (i_user_clk),
        .r_user_rst (r_user_rst),
        .i_wr_en    (w_beat && !w_fifo_full),
        .i_wr_data  (bus.i_m_axi_rdata),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_data),
        .o_rd_valid (w_fifo_valid),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign bus.o_buffer_ready  = r_buffer_ready;
    assign bus.o_m_axi_arid    = 4'(P_AXI_ID);
    assign bus.o_m_axi_araddr  = r_araddr;
    assign bus.o_m_axi_arlen   = r_arlen;
    assign bus.o_m_axi_arsize  = 3'(log2(P_AXI_DATA_WIDTH / 8));
    assign bus.o_m_axi_arburst = c_burst_incr;
    assign bus.o_m_axi_arvalid = r_arvalid;
    assign bus.o_m_axi_rready  = r_rready;
    assign bus.o_user_rd_data  = w_fifo_data;
    assign bus.o_user_rd_valid = w_fifo_valid;
    assign bus.o_rd_err        = r_rd_err;
endmodule
`default_nettype wire
